jk_excite_ctrl: RTL and testbench

Excitation controller that drives a WIDTH-bit register built from JK flip-flops toward a requested target word. The controller accepts a target via a valid/ready handshake and derives per-bit J/K excitation from the target and the bank's current Q feedback. It drives that excitation for exactly one clock, then checks the feedback, retries on mismatch, and reports done or error. It is the write-side counterpart of the JK flip-flop bank: the bank consumes J/K, and this block produces them.

---
 rtl/jk_excite_ctrl.sv | 103 ++++++++++
 tb/tb_jk_excite_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_ctrl.sv
// Drives a bank of JK flip-flops toward a requested word: one excitation cycle,
// one feedback check, bounded retries, then a done or err pulse.
module jk_excite_ctrl #(
  parameter int WIDTH      = 8,
  parameter int MAX_RETRY  = 3,
  parameter int USE_TOGGLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] mismatch
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  tgt_q, tgt_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [WIDTH-1:0]  mismatch_q, mismatch_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    retry_d    = retry_q;
    mismatch_d = mismatch_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    req_ready  = 1'b0;
    j          = '0;
    k          = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          tgt_d      = req_target;
          retry_d    = '0;
          mismatch_d = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        // Excitation follows the live feedback so unchanged bits always hold.
        if (USE_TOGGLE != 0) begin
          j = tgt_q ^ q_fb;
          k = tgt_q ^ q_fb;
        end else begin
          j = tgt_q & ~q_fb;
          k = ~tgt_q & q_fb;
        end
        state_d = CHECK;
      end
      CHECK: begin
        if (q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 1'b1;
          state_d = DRIVE;
        end else begin
          mismatch_d = tgt_q ^ q_fb;
          err_d      = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      retry_q    <= '0;
      mismatch_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      retry_q    <= retry_d;
      mismatch_q <= mismatch_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Bench: two controllers (set/reset and toggle encoding) each driving a modelled
// JK bank with an injectable stuck-at-0 mask, checked against a timeline model.
module tb_jk_excite_ctrl;
  localparam int W  = 8;
  localparam int MR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_target = '0;
  logic         bank_load = 1'b1;
  logic [W-1:0] bank_val = '0;
  logic [W-1:0] stuck = '0;

  logic         ready0, ready1, done0, done1, err0, err1;
  logic [W-1:0] b0, b1, j0, k0, j1, k1, mis0, mis1;

  int vectors = 0;
  int miscompares = 0;

  jk_excite_ctrl #(.WIDTH(W), .MAX_RETRY(MR), .USE_TOGGLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0),
    .req_target(req_target), .q_fb(b0), .j(j0), .k(k0),
    .done(done0), .err(err0), .mismatch(mis0)
  );

  jk_excite_ctrl #(.WIDTH(W), .MAX_RETRY(MR), .USE_TOGGLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
    .req_target(req_target), .q_fb(b1), .j(j1), .k(k1),
    .done(done1), .err(err1), .mismatch(mis1)
  );

  // JK banks; a stuck bit is held at 0 in the register itself.
  always @(posedge clk) begin
    if (bank_load) begin
      b0 <= bank_val & ~stuck;
      b1 <= bank_val & ~stuck;
    end else begin
      b0 <= ((j0 & ~b0) | (~k0 & b0)) & ~stuck;
      b1 <= ((j1 & ~b1) | (~k1 & b1)) & ~stuck;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: t counts cycles since accept; odd t is excitation, even t a check.
  bit           busy = 1'b0, started = 1'b0, e_done = 1'b0, e_err = 1'b0;
  int           t = 0;
  logic [W-1:0] m_tgt = '0, m_mis = '0;

  always @(posedge clk) begin
    started = 1'b1;
    e_done  = 1'b0;
    e_err   = 1'b0;
    if (rst) begin
      busy = 1'b0; t = 0; m_tgt = '0; m_mis = '0;
    end else if (!busy) begin
      if (req_valid) begin
        busy = 1'b1; t = 1; m_tgt = req_target; m_mis = '0;
      end
    end else if (t % 2 == 1) begin
      t++;
    end else if (b0 == m_tgt) begin
      e_done = 1'b1; busy = 1'b0;
    end else if (t / 2 - 1 < MR) begin
      t++;
    end else begin
      e_err = 1'b1; m_mis = m_tgt ^ b0; busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic drv;
      drv = busy && (t % 2 == 1);
      chk("ready0", ready0, !busy);
      chk("ready1", ready1, !busy);
      chk("j0", j0, drv ? (m_tgt & ~b0) : '0);
      chk("k0", k0, drv ? (~m_tgt & b0) : '0);
      chk("j1", j1, drv ? (m_tgt ^ b1) : '0);
      chk("k1", k1, drv ? (m_tgt ^ b1) : '0);
      chk("done0", done0, e_done);
      chk("done1", done1, e_done);
      chk("err0", err0, e_err);
      chk("err1", err1, e_err);
      chk("mismatch0", mis0, m_mis);
      chk("mismatch1", mis1, m_mis);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Returns at the negedge inside the excitation cycle after the accept.
  task automatic req(input logic [W-1:0] tg);
    req_valid  = 1'b1;
    req_target = tg;
    tick();
    req_valid  = 1'b0;
    req_target = ~tg;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bank_load = 1'b0;
    chk("rst_ready", ready0, 1'b1);
    chk("rst_j", j0, 8'h00);
    chk("rst_mis", mis0, 8'h00);

    // Plain set from zero
    req(8'hA5);
    chk("s1_j", j0, 8'hA5);
    chk("s1_k", k0, 8'h00);
    tick();
    chk("s1_bank", b0, 8'hA5);
    tick();
    chk("s1_done", done0, 1'b1);
    chk("s1_err", err0, 1'b0);
    $display("txn tgt=a5 done=%0b err=%0b", done0, err0);

    // Mixed set/clear, both encodings
    bank_load = 1'b1; bank_val = 8'hF0;
    tick();
    bank_load = 1'b0;
    req(8'h3C);
    chk("s2_j0", j0, 8'h0C);
    chk("s2_k0", k0, 8'hC0);
    chk("s2_j1", j1, 8'hCC);
    chk("s2_k1", k1, 8'hCC);
    tick(); tick();
    chk("s2_done0", done0, 1'b1);
    chk("s2_done1", done1, 1'b1);
    $display("txn tgt=3c done0=%0b done1=%0b", done0, done1);

    // Stuck bit exhausts retries
    bank_load = 1'b1; bank_val = 8'h00; stuck = 8'h04;
    tick();
    bank_load = 1'b0;
    req(8'h04);
    chk("s3_j_d0", j0, 8'h04);
    for (int i = 1; i <= 3; i++) begin
      tick(); tick();
      chk("s3_j_retry", j0, 8'h04);
      chk("s3_nodone", done0, 1'b0);
    end
    tick(); tick();
    chk("s3_err", err0, 1'b1);
    chk("s3_done", done0, 1'b0);
    chk("s3_mis", mis0, 8'h04);
    tick();
    chk("s3_mis_hold", mis0, 8'h04);
    $display("txn tgt=04 stuck err=1 mismatch=%0h", mis0);

    // Stuck bit released during the second retry
    req(8'h04);
    tick(); tick(); tick(); tick();
    stuck = 8'h00;
    tick(); tick();
    chk("s4_done", done0, 1'b1);
    chk("s4_mis", mis0, 8'h00);
    $display("txn tgt=04 released done=%0b", done0);

    // Back-to-back with req_valid held high
    req_valid = 1'b1; req_target = 8'h00;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("s5_ready", ready0, (i % 3 == 0));
      chk("s5_done", done0, (i % 3 == 0));
      if (i == 9) req_valid = 1'b0;
      else if (i % 3 == 0) req_target = ~req_target;
    end
    $display("txn back-to-back x3 bank=%0h", b0);

    // Reset during excitation, then during check
    req(8'h5A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6a_j", j0, 8'h00);
    chk("s6a_ready", ready0, 1'b1);
    chk("s6a_done", done0, 1'b0);
    req(8'h3C);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6b_ready", ready0, 1'b1);
    chk("s6b_done", done0, 1'b0);
    chk("s6b_err", err0, 1'b0);
    req(8'h5A);
    tick(); tick();
    chk("s6c_done", done0, 1'b1);
    chk("s6c_bank", b0, 8'h5A);
    $display("txn tgt=5a after reset done=%0b", done0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
